// File: rtl/s3_writeback.sv
// Stage-3 memory/writeback block of the 3-stage RV32I pipeline: s2->s3 register, load alignment, writeback mux, tohost CSR.
// Optional performance counters are enabled by defining S3_PERF_CNT_EN.
module s3_writeback #(
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instruction_s2,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_s2,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction_s3,
    output logic        valid_s3,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] fwd_data,
    output logic [31:0] tohost,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ARI_R  = 7'b0110011;
    localparam logic [6:0] OP_ARI_I  = 7'b0010011;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    logic [31:0] alu_r;
    logic [31:0] pc_r;
    logic [31:0] csr_old_r;
    logic [31:0] csr_rd_s;
    logic        tohost_we_s;
    logic [6:0]  opcode_s2_s;
    logic [11:0] csr_addr_s2_s;
    logic [6:0]  opcode_s3_s;

    // Offset-aligned, sign/zero-extended load data; undefined func3 returns the full word.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            2'd3:    b = d[31:24];
            default: b = d[7:0];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h000000, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0000, h};
            default: return d;
        endcase
    endfunction

    assign opcode_s2_s   = instruction_s2[6:0];
    assign csr_addr_s2_s = instruction_s2[31:20];
    assign opcode_s3_s   = instruction_s3[6:0];
    assign tohost_we_s   = (opcode_s2_s == OP_CSR) && (csr_addr_s2_s == TOHOST_ADDR) &&
                           ((instruction_s2[14:12] == 3'b001) || (instruction_s2[14:12] == 3'b101));

    // CSR read value seen by the instruction in s2 (pre-edge register values).
    always_comb begin
        csr_rd_s = 32'h0000_0000;
        if (opcode_s2_s == OP_CSR && csr_addr_s2_s == TOHOST_ADDR) begin
            csr_rd_s = tohost;
`ifdef S3_PERF_CNT_EN
        end else if (opcode_s2_s == OP_CSR && csr_addr_s2_s == 12'hC00) begin
            csr_rd_s = cycle_cnt;
        end else if (opcode_s2_s == OP_CSR && csr_addr_s2_s == 12'hC02) begin
            csr_rd_s = instret_cnt;
`endif
        end else begin
            csr_rd_s = 32'h0000_0000;
        end
    end

    // s3 pipeline register and tohost CSR: reset > stall > flush > capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instruction_s3 <= NOP_INSTR;
            valid_s3       <= 1'b0;
            alu_r          <= 32'h0000_0000;
            pc_r           <= 32'h0000_0000;
            csr_old_r      <= 32'h0000_0000;
            tohost         <= 32'h0000_0000;
        end else if (stall) begin
            instruction_s3 <= instruction_s3;
            valid_s3       <= valid_s3;
            alu_r          <= alu_r;
            pc_r           <= pc_r;
            csr_old_r      <= csr_old_r;
            tohost         <= tohost;
        end else if (flush) begin
            instruction_s3 <= NOP_INSTR;
            valid_s3       <= 1'b0;
            alu_r          <= 32'h0000_0000;
            pc_r           <= 32'h0000_0000;
            csr_old_r      <= 32'h0000_0000;
            tohost         <= tohost;
        end else begin
            instruction_s3 <= instruction_s2;
            valid_s3       <= 1'b1;
            alu_r          <= alu_result;
            pc_r           <= pc_s2;
            csr_old_r      <= csr_rd_s;
            tohost         <= tohost_we_s ? alu_result : tohost;
        end
    end

`ifdef S3_PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'h0000_0000;
            instret_cnt <= 32'h0000_0000;
        end else begin
            cycle_cnt   <= cycle_cnt + 32'd1;
            instret_cnt <= (valid_s3 && !stall) ? instret_cnt + 32'd1 : instret_cnt;
        end
    end
`else
    assign cycle_cnt   = 32'h0000_0000;
    assign instret_cnt = 32'h0000_0000;
`endif

    assign rf_waddr = instruction_s3[11:7];
    assign fwd_data = rf_wdata;

    // Register-file write enable; not gated by stall because a repeated write is harmless.
    always_comb begin
        rf_we = 1'b0;
        case (opcode_s3_s)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_ARI_R, OP_ARI_I, OP_CSR:
                rf_we = valid_s3 && (rf_waddr != 5'd0);
            default:
                rf_we = 1'b0;
        endcase
    end

    // Writeback data select from s3 state.
    always_comb begin
        rf_wdata = alu_r;
        case (opcode_s3_s)
            OP_LOAD:         rf_wdata = load_extract(instruction_s3[14:12], alu_r[1:0], mem_rdata);
            OP_JAL, OP_JALR: rf_wdata = pc_r + 32'd4;
            OP_CSR:          rf_wdata = csr_old_r;
            default:         rf_wdata = alu_r;
        endcase
    end

endmodule

// File: tb/tb_s3_writeback.sv
// Self-checking bench for s3_writeback: directed steps followed by random traffic against a transaction-level model.
module tb_s3_writeback;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic [31:0] instruction_s2, alu_result, pc_s2, mem_rdata;
    logic [31:0] instruction_s3, rf_wdata, fwd_data, tohost, cycle_cnt, instret_cnt;
    logic        valid_s3, rf_we;
    logic [4:0]  rf_waddr;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: the instruction sitting in s3 and the architectural CSRs.
    logic [31:0] m_ins, m_alu, m_pc, m_old, m_toh, m_cyc, m_ret;
    logic        m_val;

    s3_writeback dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .instruction_s2(instruction_s2), .alu_result(alu_result), .pc_s2(pc_s2),
        .mem_rdata(mem_rdata), .instruction_s3(instruction_s3), .valid_s3(valid_s3),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_data(fwd_data),
        .tohost(tohost), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ins = 32'h0000_0013; m_val = 1'b0; m_alu = 32'h0; m_pc = 32'h0;
        m_old = 32'h0; m_toh = 32'h0; m_cyc = 32'h0; m_ret = 32'h0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic [31:0] ins,
                              input logic [31:0] a, input logic [31:0] p);
        logic [31:0] rd_v, cyc0, ret0;
        cyc0 = m_cyc; ret0 = m_ret;
`ifdef S3_PERF_CNT_EN
        m_cyc = m_cyc + 32'd1;
        if (m_val && !st) m_ret = m_ret + 32'd1;
`endif
        if (st) begin
            // everything holds
        end else if (fl) begin
            m_ins = 32'h0000_0013; m_val = 1'b0;
        end else begin
            rd_v = 32'h0;
            if (ins[6:0] == 7'h73) begin
                if (ins[31:20] == 12'h51E) rd_v = m_toh;
`ifdef S3_PERF_CNT_EN
                if (ins[31:20] == 12'hC00) rd_v = cyc0;
                if (ins[31:20] == 12'hC02) rd_v = ret0;
`endif
                if (ins[31:20] == 12'h51E && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)) m_toh = a;
            end
            m_ins = ins; m_alu = a; m_pc = p; m_old = rd_v; m_val = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_wdata(input logic [31:0] mem);
        logic [31:0] bv, hv;
        bv = (mem >> (8 * m_alu[1:0])) & 32'h0000_00FF;
        hv = (mem >> (16 * m_alu[1])) & 32'h0000_FFFF;
        case (m_ins[6:0])
            7'h03: case (m_ins[14:12])
                       3'd0:    return (bv >= 32'h80) ? bv - 32'h100 : bv;
                       3'd4:    return bv;
                       3'd1:    return (hv >= 32'h8000) ? hv - 32'h10000 : hv;
                       3'd5:    return hv;
                       default: return mem;
                   endcase
            7'h6F, 7'h67: return m_pc + 32'd4;
            7'h73:        return m_old;
            default:      return m_alu;
        endcase
    endfunction

    function automatic logic exp_we();
        logic writes;
        case (m_ins[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h33, 7'h13, 7'h73: writes = 1'b1;
            default: writes = 1'b0;
        endcase
        return m_val && writes && (m_ins[11:7] != 5'd0);
    endfunction

    task automatic cyc(input logic st, input logic fl, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] p);
        rst_n = 1'b1; stall = st; flush = fl;
        instruction_s2 = ins; alu_result = a; pc_s2 = p;
        @(posedge clk);
        model_edge(st, fl, ins, a, p);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'($urandom); flush = 1'($urandom);
        @(posedge clk);
        model_reset();
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] mem);
        mem_rdata = mem;
        #1;
        chk({tag, ".ins"},     instruction_s3, m_ins);
        chk({tag, ".valid"},   {31'd0, valid_s3}, {31'd0, m_val});
        chk({tag, ".we"},      {31'd0, rf_we}, {31'd0, exp_we()});
        chk({tag, ".waddr"},   {27'd0, rf_waddr}, {27'd0, m_ins[11:7]});
        if (m_val) begin
            chk({tag, ".wdata"}, rf_wdata, exp_wdata(mem));
            chk({tag, ".fwd"},   fwd_data, exp_wdata(mem));
        end
        chk({tag, ".tohost"},  tohost, m_toh);
        chk({tag, ".cycle"},   cycle_cnt, m_cyc);
        chk({tag, ".instret"}, instret_cnt, m_ret);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [11:0] csrs [4];
        logic [31:0] ins;
        ops  = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h73};
        csrs = '{12'h51E, 12'hC00, 12'hC02, 12'h340};
        ins = $urandom;
        ins[6:0] = ops[$urandom_range(0, 9)];
        if (ins[6:0] == 7'h73) begin
            ins[31:20] = csrs[$urandom_range(0, 3)];
            if (ins[13:12] == 2'd0) ins[12] = 1'b1;
        end
        return ins;
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        instruction_s2 = 32'h0; alu_result = 32'h0; pc_s2 = 32'h0; mem_rdata = 32'h0;
        model_reset();

        // Reset: bubble in s3, no write.
        do_reset();
        check_all("rst", 32'h0);
        chk("rst.ins_c", instruction_s3, 32'h0000_0013);
        chk("rst.we_c", {31'd0, rf_we}, 32'd0);

        // addi x5,x0,7
        cyc(1'b0, 1'b0, 32'h0070_0293, 32'd7, 32'h100);
        check_all("addi", 32'h0);
        chk("addi.we_c", {31'd0, rf_we}, 32'd1);
        chk("addi.waddr_c", {27'd0, rf_waddr}, 32'd5);
        chk("addi.wdata_c", rf_wdata, 32'd7);

        // Stall three cycles while s2 changes, then release.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, rand_instr(), $urandom, $urandom);
            check_all("stall", 32'h0);
            chk("stall.ins_c", instruction_s3, 32'h0070_0293);
            chk("stall.wdata_c", rf_wdata, 32'd7);
        end
        cyc(1'b0, 1'b0, 32'h0030_0313, 32'd3, 32'h104);
        chk("unstall.ins_c", instruction_s3, 32'h0030_0313);

        // Loads at offset 2 with mem_rdata 0x12F45678.
        cyc(1'b0, 1'b0, 32'h0000_8303, 32'h0000_0102, 32'h108);
        check_all("lb", 32'h12F4_5678);
        chk("lb.c", rf_wdata, 32'hFFFF_FFF4);
        cyc(1'b0, 1'b0, 32'h0000_C303, 32'h0000_0102, 32'h10C);
        check_all("lbu", 32'h12F4_5678);
        chk("lbu.c", rf_wdata, 32'h0000_00F4);
        cyc(1'b0, 1'b0, 32'h0000_9303, 32'h0000_0102, 32'h110);
        check_all("lh", 32'h12F4_5678);
        chk("lh.c", rf_wdata, 32'h0000_12F4);
        cyc(1'b0, 1'b0, 32'h0000_A303, 32'h0000_0102, 32'h114);
        check_all("lw", 32'h12F4_5678);
        chk("lw.c", rf_wdata, 32'h12F4_5678);

        // JAL link value, including wrap at the top of memory; sw and addi x0 do not write.
        cyc(1'b0, 1'b0, 32'h0000_00EF, 32'h0, 32'h0000_1000);
        check_all("jal", 32'h0);
        chk("jal.c", rf_wdata, 32'h0000_1004);
        cyc(1'b0, 1'b0, 32'h0000_00EF, 32'h0, 32'hFFFF_FFFC);
        chk("jalwrap.c", rf_wdata, 32'h0000_0000);
        cyc(1'b0, 1'b0, 32'h0020_A023, 32'h200, 32'h118);
        chk("sw.we_c", {31'd0, rf_we}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h11C);
        chk("addix0.we_c", {31'd0, rf_we}, 32'd0);

        // tohost: write 0xA, stalled and flushed attempts are ignored, then csrrw x3 swaps in 1.
        cyc(1'b0, 1'b0, 32'h51E0_9073, 32'h0000_000A, 32'h120);
        chk("toh.a_c", tohost, 32'h0000_000A);
        cyc(1'b1, 1'b0, 32'h51E0_91F3, 32'h1, 32'h124);
        check_all("toh.stall", 32'h0);
        chk("toh.stall_c", tohost, 32'h0000_000A);
        cyc(1'b0, 1'b1, 32'h51E0_91F3, 32'h1, 32'h124);
        check_all("toh.flush", 32'h0);
        chk("toh.flush_c", tohost, 32'h0000_000A);
        chk("toh.flushv_c", {31'd0, valid_s3}, 32'd0);
        cyc(1'b0, 1'b0, 32'h51E0_91F3, 32'h1, 32'h124);
        check_all("toh.csrrw", 32'h0);
        chk("toh.new_c", tohost, 32'h0000_0001);
        chk("toh.old_c", rf_wdata, 32'h0000_000A);
        chk("toh.waddr_c", {27'd0, rf_waddr}, 32'd3);

        // Counters: 10 cycles after reset, two stalls and one flush.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc((i == 3 || i == 4), (i == 6), 32'h0010_0093, 32'd1, 32'h200 + 32'(i * 4));
        end
        check_all("perf", 32'h0);
`ifdef S3_PERF_CNT_EN
        chk("perf.cycle_c", cycle_cnt, 32'd10);
`else
        chk("perf.cycle_c", cycle_cnt, 32'd0);
        chk("perf.instret_c", instret_cnt, 32'd0);
`endif

        // Random traffic with occasional stall, flush and reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                    rand_instr(), $urandom, $urandom);
            end
            check_all("rand", $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
